// File: rtl/alu_seq_if.sv
// Operation request/result bundle for the multi-cycle ALU.
// Start is sampled only when Busy is low; Busy covers RUN and DONE; Done is a one-cycle pulse; Out/flags hold until the next completion.
interface alu_seq_if #(
  parameter int WIDTH  = 8,
  parameter int LFSR_W = 7,
  parameter int CNT_W  = 4
);
  logic             Start;
  logic [3:0]       OP;
  logic [WIDTH-1:0] InputA;
  logic [WIDTH-1:0] InputB;
  logic [CNT_W-1:0] Count;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Out;
  logic             Zero;
  logic             Negative;
  logic             Carry;

  modport master (
    output Start, OP, InputA, InputB, Count,
    input  Busy, Done, Out, Zero, Negative, Carry
  );

  modport slave (
    input  Start, OP, InputA, InputB, Count,
    output Busy, Done, Out, Zero, Negative, Carry
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: one operation per Start/Done handshake, with shifts and LFSR
// stepping done one step per clock for Count steps.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int LFSR_W = 7,
  parameter int CNT_W  = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3,
                         OP_LSL = 4'd4, OP_LSR = 4'd5, OP_CMP = 4'd6, OP_PAR = 4'd7,
                         OP_LFSR = 4'd8;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, out_q, seed, res;
  logic [CNT_W-1:0] rem;
  logic             cy_q, zero_q, neg_q, carry_q, res_c, lfsr_fb, start_iter;
  logic [WIDTH:0]   sum, diff;

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.Start) state_nx = RUN;
      RUN:     if (rem == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign start_iter = (bus.OP == OP_LSL) || (bus.OP == OP_LSR) || (bus.OP == OP_LFSR);
  assign lfsr_fb    = ^(a_q[LFSR_W-1:0] & work_q[LFSR_W-1:0]);
  assign sum        = {1'b0, a_q} + {1'b0, b_q};
  assign diff       = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    seed = '0;
    seed[LFSR_W-1:0] = bus.InputB[LFSR_W-1:0];
  end

  // Shift/LFSR results are already sitting in work_q when rem reaches zero.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (op_q)
      OP_ADD:         begin res = sum[WIDTH-1:0];  res_c = sum[WIDTH];  end
      OP_SUB, OP_CMP: begin res = diff[WIDTH-1:0]; res_c = diff[WIDTH]; end
      OP_XOR:         res = a_q ^ b_q;
      OP_AND:         res = a_q & b_q;
      OP_LSL, OP_LSR: begin res = work_q; res_c = cy_q; end
      OP_PAR:         res = {^b_q[WIDTH-2:0], b_q[WIDTH-2:0]};
      OP_LFSR:        res = work_q;
      default:        res = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      rem     <= '0;
      cy_q    <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Start) begin
          op_q   <= bus.OP;
          a_q    <= bus.InputA;
          b_q    <= bus.InputB;
          cy_q   <= 1'b0;
          rem    <= start_iter ? bus.Count : '0;
          work_q <= (bus.OP == OP_LFSR) ? seed : bus.InputA;
        end
        RUN: if (rem != '0) begin
          rem <= rem - CNT_W'(1);
          case (op_q)
            OP_LSL:  {cy_q, work_q} <= {work_q, 1'b0};
            OP_LSR:  {work_q, cy_q} <= {1'b0, work_q};
            OP_LFSR: work_q[LFSR_W-1:0] <= {work_q[LFSR_W-2:0], lfsr_fb};
            default: ;
          endcase
        end else begin
          out_q   <= res;
          zero_q  <= (res == '0);
          neg_q   <= res[WIDTH-1];
          carry_q <= res_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy     = (state != IDLE);
  assign bus.Done     = (state == DONE);
  assign bus.Out      = out_q;
  assign bus.Zero     = zero_q;
  assign bus.Negative = neg_q;
  assign bus.Carry    = carry_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: reset, every opcode class, shift/LFSR boundaries,
// Start-while-busy and mid-run reset abort.
module tb_alu_seq;
  logic       Clk;
  logic       Reset;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;
  int         lat, bc;
  logic       ba;

  alu_seq_if #(.WIDTH(8), .LFSR_W(7), .CNT_W(4)) bus ();

  alu_seq #(.WIDTH(8), .LFSR_W(7), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .dbg_state(dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Returns lat = negedge index after the accepting edge where Done is seen (-1 on timeout),
  // bc = Busy cycles seen up to Done, ba = Busy|Done on the following cycle.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] cnt, output int l, output int busy_cyc, output logic busy_after);
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.OP = op; bus.InputA = a; bus.InputB = b; bus.Count = cnt;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    l = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (bus.Busy) busy_cyc++;
      if (bus.Done) begin l = k; break; end
    end
    @(negedge Clk);
    busy_after = bus.Busy | bus.Done;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.Start = 1'b0; bus.OP = 4'd0; bus.InputA = 8'h00; bus.InputB = 8'h00; bus.Count = 4'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    checks++; if (bus.Out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.Zero, bus.Negative, bus.Carry}); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  task automatic test_add();
    run_op(4'd0, 8'hF0, 8'h20, 4'd5, lat, bc, ba);
    checks++; if (bus.Out !== 8'h10) begin failures++; $display("FAIL add_out got=%h exp=10", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b001) begin failures++; $display("FAIL add_flags got=%b exp=001", {bus.Zero, bus.Negative, bus.Carry}); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=2", bc); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL add_idle_after got=%b exp=0", ba); end
    run_op(4'd1, 8'h10, 8'h20, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'hF0) begin failures++; $display("FAIL sub_out got=%h exp=f0", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b011) begin failures++; $display("FAIL sub_flags got=%b exp=011", {bus.Zero, bus.Negative, bus.Carry}); end
    run_op(4'd3, 8'hF0, 8'h3C, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'h30) begin failures++; $display("FAIL and_out got=%h exp=30", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b000) begin failures++; $display("FAIL and_flags got=%b exp=000", {bus.Zero, bus.Negative, bus.Carry}); end
  endtask

  task automatic test_cmp();
    run_op(4'd6, 8'h05, 8'h05, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'h00) begin failures++; $display("FAIL cmp_eq_out got=%h exp=00", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b100) begin failures++; $display("FAIL cmp_eq_flags got=%b exp=100", {bus.Zero, bus.Negative, bus.Carry}); end
    run_op(4'd6, 8'h03, 8'h05, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'hFE) begin failures++; $display("FAIL cmp_lt_out got=%h exp=fe", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b011) begin failures++; $display("FAIL cmp_lt_flags got=%b exp=011", {bus.Zero, bus.Negative, bus.Carry}); end
  endtask

  task automatic test_shift();
    run_op(4'd4, 8'h81, 8'h00, 4'd3, lat, bc, ba);
    checks++; if (bus.Out !== 8'h08) begin failures++; $display("FAIL lsl3_out got=%h exp=08", bus.Out); end
    checks++; if (bus.Carry !== 1'b0) begin failures++; $display("FAIL lsl3_carry got=%b exp=0", bus.Carry); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL lsl3_latency got=%0d exp=5", lat); end
    run_op(4'd5, 8'h01, 8'h00, 4'd1, lat, bc, ba);
    checks++; if (bus.Out !== 8'h00) begin failures++; $display("FAIL lsr1_out got=%h exp=00", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b101) begin failures++; $display("FAIL lsr1_flags got=%b exp=101", {bus.Zero, bus.Negative, bus.Carry}); end
    run_op(4'd4, 8'hFF, 8'h00, 4'd8, lat, bc, ba);
    checks++; if (bus.Out !== 8'h00) begin failures++; $display("FAIL lsl8_out got=%h exp=00", bus.Out); end
    checks++; if (bus.Carry !== 1'b1) begin failures++; $display("FAIL lsl8_carry got=%b exp=1", bus.Carry); end
    run_op(4'd4, 8'hC3, 8'h00, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'hC3) begin failures++; $display("FAIL lsl0_out got=%h exp=c3", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b010) begin failures++; $display("FAIL lsl0_flags got=%b exp=010", {bus.Zero, bus.Negative, bus.Carry}); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL lsl0_latency got=%0d exp=2", lat); end
    run_op(4'd5, 8'hAA, 8'h00, 4'd15, lat, bc, ba);
    checks++; if (bus.Out !== 8'h00) begin failures++; $display("FAIL lsr15_out got=%h exp=00", bus.Out); end
    checks++; if (bus.Carry !== 1'b0) begin failures++; $display("FAIL lsr15_carry got=%b exp=0", bus.Carry); end
    checks++; if (lat !== 17) begin failures++; $display("FAIL lsr15_latency got=%0d exp=17", lat); end
  endtask

  task automatic test_lfsr();
    run_op(4'd8, 8'h60, 8'h41, 4'd2, lat, bc, ba);
    checks++; if (bus.Out !== 8'h06) begin failures++; $display("FAIL lfsr2_out got=%h exp=06", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b000) begin failures++; $display("FAIL lfsr2_flags got=%b exp=000", {bus.Zero, bus.Negative, bus.Carry}); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL lfsr2_latency got=%0d exp=4", lat); end
    run_op(4'd8, 8'h60, 8'h41, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'h41) begin failures++; $display("FAIL lfsr0_out got=%h exp=41", bus.Out); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL lfsr0_latency got=%0d exp=2", lat); end
    run_op(4'd8, 8'h60, 8'hC1, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'h41) begin failures++; $display("FAIL lfsr_seed_trunc got=%h exp=41", bus.Out); end
  endtask

  task automatic test_parity_nop();
    run_op(4'd7, 8'h00, 8'h07, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'h87) begin failures++; $display("FAIL parity_out got=%h exp=87", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b010) begin failures++; $display("FAIL parity_flags got=%b exp=010", {bus.Zero, bus.Negative, bus.Carry}); end
    run_op(4'hF, 8'hFF, 8'hFF, 4'd9, lat, bc, ba);
    checks++; if (bus.Out !== 8'h00) begin failures++; $display("FAIL nop_out got=%h exp=00", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b100) begin failures++; $display("FAIL nop_flags got=%b exp=100", {bus.Zero, bus.Negative, bus.Carry}); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL nop_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_abort();
    int seen;
    run_op(4'd2, 8'h5A, 8'hFF, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'hA5) begin failures++; $display("FAIL xor_out got=%h exp=a5", bus.Out); end
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.OP = 4'd5; bus.InputA = 8'hFF; bus.InputB = 8'h00; bus.Count = 4'd15;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.OP = 4'd0; bus.InputA = 8'h01; bus.InputB = 8'h01; bus.Count = 4'd0;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(negedge Clk);
    checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL abort_running got=%b exp=1", bus.Busy); end
    checks++; if (bus.Out !== 8'hA5) begin failures++; $display("FAIL abort_out_held got=%h exp=a5", bus.Out); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    bus.Start = 1'b1; bus.OP = 4'd0; bus.InputA = 8'h01; bus.InputB = 8'h01;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(negedge Clk);
    checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.Done); end
    checks++; if (bus.Out !== 8'h00) begin failures++; $display("FAIL abort_out got=%h exp=00", bus.Out); end
    checks++; if ({bus.Zero, bus.Negative, bus.Carry} !== 3'b000) begin failures++; $display("FAIL abort_flags got=%b exp=000", {bus.Zero, bus.Negative, bus.Carry}); end
    @(posedge Clk); #1;
    Reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (bus.Busy || bus.Done) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", seen); end
    run_op(4'd0, 8'h01, 8'h01, 4'd0, lat, bc, ba);
    checks++; if (bus.Out !== 8'h02) begin failures++; $display("FAIL post_abort_add got=%h exp=02", bus.Out); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL post_abort_latency got=%0d exp=2", lat); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_cmp();
    test_shift();
    test_lfsr();
    test_parity_nop();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
